// File: rtl/structural_demultiplexer.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready holding
// registers and delivered-word counters. Channel index = {addr1, addr0}.
module structural_demultiplexer #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 addr0,
    input  logic                 addr1,
    input  logic [WIDTH-1:0]     in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out0,
    output logic [WIDTH-1:0]     out1,
    output logic [WIDTH-1:0]     out2,
    output logic [WIDTH-1:0]     out3,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [CNT_WIDTH-1:0] count0,
    output logic [CNT_WIDTH-1:0] count1,
    output logic [CNT_WIDTH-1:0] count2,
    output logic [CNT_WIDTH-1:0] count3
);

    logic [1:0]           sel;
    logic                 accept;
    logic [3:0]           drain;
    logic [WIDTH-1:0]     data_q  [4];
    logic [WIDTH-1:0]     data_d  [4];
    logic [3:0]           valid_q;
    logic [3:0]           valid_d;
    logic [CNT_WIDTH-1:0] cnt_q   [4];
    logic [CNT_WIDTH-1:0] cnt_d   [4];

    assign sel = {addr1, addr0};

    // Input handshake: only the selected channel can stall the producer.
    always_comb begin
        in_ready = !reset && (!valid_q[sel] || out_ready[sel]);
        accept   = in_valid && in_ready;
    end

    // Per-channel next state: drain frees the slot, accept refills it in the same cycle.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            data_d[k]  = data_q[k];
            valid_d[k] = valid_q[k];
            cnt_d[k]   = cnt_q[k];
            drain[k]   = valid_q[k] && out_ready[k];
            if (drain[k]) begin
                valid_d[k] = 1'b0;
                cnt_d[k]   = cnt_q[k] + CNT_WIDTH'(1);
            end
            if (accept && (sel == 2'(k))) begin
                data_d[k]  = in;
                valid_d[k] = 1'b1;
            end
        end
    end

    // Channel registers; reset discards any held words and clears counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    // Outputs come straight from the registers, data is not gated by valid.
    always_comb begin
        out0      = data_q[0];
        out1      = data_q[1];
        out2      = data_q[2];
        out3      = data_q[3];
        out_valid = valid_q;
        count0    = cnt_q[0];
        count1    = cnt_q[1];
        count2    = cnt_q[2];
        count3    = cnt_q[3];
    end

endmodule

// File: tb/tb_structural_demultiplexer.sv
// Directed bench for structural_demultiplexer: table of single-cycle
// vectors plus hand-written sequences for refill, wrap, reset and idle X.
module tb_structural_demultiplexer;

    logic       clk = 1'b0;
    logic       reset;
    logic       addr0, addr1;
    logic [0:0] din;
    logic       in_valid;
    logic [3:0] out_ready;

    logic       in_ready;
    logic [0:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [7:0] count0, count1, count2, count3;

    logic       in_ready_w;
    logic [0:0] w_out0, w_out1, w_out2, w_out3;
    logic [3:0] out_valid_w;
    logic [1:0] w_cnt0, w_cnt1, w_cnt2, w_cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    structural_demultiplexer #(.WIDTH(1), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .addr0(addr0), .addr1(addr1),
        .in(din), .in_valid(in_valid), .in_ready(in_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out_valid(out_valid), .out_ready(out_ready),
        .count0(count0), .count1(count1), .count2(count2), .count3(count3)
    );

    structural_demultiplexer #(.WIDTH(1), .CNT_WIDTH(2)) dut_w (
        .clk(clk), .reset(reset), .addr0(addr0), .addr1(addr1),
        .in(din), .in_valid(in_valid), .in_ready(in_ready_w),
        .out0(w_out0), .out1(w_out1), .out2(w_out2), .out3(w_out3),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .count0(w_cnt0), .count1(w_cnt1), .count2(w_cnt2), .count3(w_cnt3)
    );

    typedef struct {
        logic [1:0] addr;
        logic       d;
        logic       v;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        logic       exp_out;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic d, input logic v, input logic [3:0] r);
        {addr1, addr0} = a;
        din            = d;
        in_valid       = v;
        out_ready      = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel_out(input logic [1:0] a);
        case (a)
            2'd0:    return out0[0];
            2'd1:    return out1[0];
            2'd2:    return out2[0];
            default: return out3[0];
        endcase
    endfunction

    initial begin
        // route to each channel with all consumers ready
        vecs[0] = '{2'd0, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1};
        vecs[1] = '{2'd1, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b0};
        vecs[2] = '{2'd2, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0100, 1'b1};
        vecs[3] = '{2'd3, 1'b0, 1'b1, 4'hF, 1'b1, 4'b1000, 1'b0};
        vecs[4] = '{2'd0, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b1};
        // backpressure on channel 2, channel 1 unaffected
        vecs[5] = '{2'd2, 1'b1, 1'b1, 4'h0, 1'b1, 4'b0100, 1'b1};
        vecs[6] = '{2'd2, 1'b0, 1'b1, 4'h0, 1'b0, 4'b0100, 1'b1};
        vecs[7] = '{2'd1, 1'b1, 1'b1, 4'h0, 1'b1, 4'b0110, 1'b1};

        reset = 1'b1;
        drive(2'd0, 1'b0, 1'b0, 4'h0);
        #1;
        chk("rdy_in_reset", 32'(in_ready), 32'd0);
        tick(); tick();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_count0", 32'(count0), 32'd0);
        reset = 1'b0;
        #1;
        chk("rdy_after_reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].addr, vecs[i].d, vecs[i].v, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d_rdy", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            tick();
            chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("vec%0d_out", i), 32'(sel_out(vecs[i].addr)), 32'(vecs[i].exp_out));
            if (i == 4) begin
                chk("route_cnt0", 32'(count0), 32'd1);
                chk("route_cnt1", 32'(count1), 32'd1);
                chk("route_cnt2", 32'(count2), 32'd1);
                chk("route_cnt3", 32'(count3), 32'd1);
            end
        end
        chk("bp_cnt2", 32'(count2), 32'd1);

        // same-cycle drain and refill on channel 3
        drive(2'd3, 1'b1, 1'b1, 4'h0);
        tick();
        chk("fill3_ov", 32'(out_valid), 32'b1110);
        chk("fill3_out", 32'(out3), 32'd1);
        drive(2'd3, 1'b0, 1'b1, 4'b1000);
        #1;
        chk("refill3_rdy", 32'(in_ready), 32'd1);
        tick();
        chk("refill3_ov", 32'(out_valid), 32'b1110);
        chk("refill3_out", 32'(out3), 32'd0);
        chk("refill3_cnt", 32'(count3), 32'd2);

        // fill channel 0, then assert reset between edges
        drive(2'd0, 1'b1, 1'b1, 4'h0);
        tick();
        chk("full_ov", 32'(out_valid), 32'b1111);
        drive(2'd0, 1'b0, 1'b0, 4'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_ov", 32'(out_valid), 32'd0);
        chk("async_rst_cnt3", 32'(count3), 32'd0);
        chk("async_rst_cnt0", 32'(count0), 32'd0);
        chk("async_rst_out0", 32'(out0), 32'd0);
        chk("async_rst_rdy", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        drive(2'd0, 1'b1, 1'b1, 4'b0001);
        #1;
        chk("post_rst_rdy", 32'(in_ready), 32'd1);

        // five words into channel 0 with consumer ready: count wraps at 2 bits
        for (int i = 0; i < 5; i++) begin
            drive(2'd0, logic'(i % 2 == 0), 1'b1, 4'b0001);
            tick();
            chk($sformatf("wrap_ov%0d", i), 32'(out_valid), 32'b0001);
            chk($sformatf("wrap_cntw%0d", i), 32'(w_cnt0), 32'(i % 4));
        end
        drive(2'd0, 1'b0, 1'b0, 4'b0001);
        tick();
        chk("wrap_cnt_w", 32'(w_cnt0), 32'd1);
        chk("wrap_cnt_8", 32'(count0), 32'd5);
        chk("wrap_ov_end", 32'(out_valid), 32'd0);

        // park one word in channel 2, then idle with X address/data
        drive(2'd2, 1'b1, 1'b1, 4'h0);
        tick();
        addr0     = 1'bx;
        addr1     = 1'bx;
        din       = 1'bx;
        in_valid  = 1'b0;
        out_ready = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_ov%0d", i), 32'(out_valid), 32'b0100);
            chk($sformatf("idle_out2_%0d", i), 32'(out2), 32'd1);
            chk($sformatf("idle_out0_%0d", i), 32'(out0), 32'd1);
            chk($sformatf("idle_cnt0_%0d", i), 32'(count0), 32'd5);
            chk($sformatf("idle_cnt2_%0d", i), 32'(count2), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
